// File: rtl/gf_mult_arbiter.sv
// rtl/gf_mult_arbiter.sv - round-robin scheduler sharing one registered carry-less multiplier
module gf_mult_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MULT_LAT   = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic                          mult_enable,
  output logic [DATA_WIDTH-1:0]         mult_a,
  output logic [DATA_WIDTH-1:0]         mult_b,
  input  logic [2*DATA_WIDTH-1:0]       mult_result,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic [31:0]                   op_count
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]      outstanding_q, outstanding_d;
  logic [ID_W-1:0]         ptr_q, ptr_d;
  logic                    mult_enable_q, mult_enable_d;
  logic [DATA_WIDTH-1:0]   mult_a_q, mult_a_d;
  logic [DATA_WIDTH-1:0]   mult_b_q, mult_b_d;
  logic [MULT_LAT:0]       tag_vld_q, tag_vld_d;
  logic [ID_W-1:0]         tag_id_q [MULT_LAT+1];
  logic [ID_W-1:0]         tag_id_d [MULT_LAT+1];
  logic [NUM_REQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [31:0]             op_count_q, op_count_d;

  logic [NUM_REQ-1:0]      busy;
  logic [NUM_REQ-1:0]      eligible;
  logic                    grant_found;
  logic [ID_W-1:0]         grant_id;
  logic [NUM_REQ-1:0]      grant_onehot;
  logic                    transfer;
  logic                    tag_out_vld;
  logic [ID_W-1:0]         tag_out_id;
  int                      idx_c;

  // A requester whose response is on rsp_valid this cycle is free again, allowing back-to-back reuse.
  always_comb begin
    busy     = outstanding_q & ~rsp_valid_q;
    eligible = req_valid & ~busy;
  end

  // Round-robin search over the eligible set starting at ptr.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    idx_c       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_c = (int'(ptr_q) + k) % NUM_REQ;
      if (!grant_found && eligible[idx_c[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_id    = idx_c[ID_W-1:0];
      end
    end
  end

  // Handshake: ready is the one-hot grant, suppressed while reset is asserted.
  always_comb begin
    grant_onehot = grant_found ? (NUM_REQ'(1) << grant_id) : '0;
    req_ready    = rst_n ? grant_onehot : '0;
    transfer     = grant_found & rst_n;
  end

  // Issue stage: latch granted operands, advance ptr, track outstanding, push tag.
  always_comb begin
    ptr_d         = ptr_q;
    mult_a_d      = mult_a_q;
    mult_b_d      = mult_b_q;
    mult_enable_d = 1'b1;
    outstanding_d = busy;
    if (transfer) begin
      ptr_d         = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + ID_W'(1);
      mult_a_d      = req_a[grant_id*DATA_WIDTH +: DATA_WIDTH];
      mult_b_d      = req_b[grant_id*DATA_WIDTH +: DATA_WIDTH];
      outstanding_d = busy | grant_onehot;
    end
  end

  // Tag pipe: one entry per cycle, aligned so its output matches a valid mult_result.
  always_comb begin
    tag_vld_d[0] = transfer;
    tag_id_d[0]  = grant_id;
    for (int i = 1; i <= MULT_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    tag_out_vld = tag_vld_q[MULT_LAT];
    tag_out_id  = tag_id_q[MULT_LAT];
  end

  // Response stage: capture the product and pulse the originator's valid bit.
  always_comb begin
    rsp_valid_d = '0;
    rsp_data_d  = rsp_data_q;
    op_count_d  = op_count_q;
    if (tag_out_vld) begin
      rsp_valid_d = NUM_REQ'(1) << tag_out_id;
      rsp_data_d  = mult_result;
      op_count_d  = op_count_q + 32'd1;
    end
  end

  // State registers; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding_q <= '0;
      ptr_q         <= '0;
      mult_enable_q <= 1'b0;
      mult_a_q      <= '0;
      mult_b_q      <= '0;
      tag_vld_q     <= '0;
      for (int i = 0; i <= MULT_LAT; i++) tag_id_q[i] <= '0;
      rsp_valid_q   <= '0;
      rsp_data_q    <= '0;
      op_count_q    <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      ptr_q         <= ptr_d;
      mult_enable_q <= mult_enable_d;
      mult_a_q      <= mult_a_d;
      mult_b_q      <= mult_b_d;
      tag_vld_q     <= tag_vld_d;
      for (int i = 0; i <= MULT_LAT; i++) tag_id_q[i] <= tag_id_d[i];
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      op_count_q    <= op_count_d;
    end
  end

  assign mult_enable = mult_enable_q;
  assign mult_a      = mult_a_q;
  assign mult_b      = mult_b_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_gf_mult_arbiter.sv
// tb/tb_gf_mult_arbiter.sv - directed self-checking bench for gf_mult_arbiter
module tb_gf_mult_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic         mult_enable;
  logic [31:0]  mult_a;
  logic [31:0]  mult_b;
  logic [63:0]  mult_result = '0;
  logic [3:0]   rsp_valid;
  logic [63:0]  rsp_data;
  logic [31:0]  op_count;

  int total;
  int bad;

  logic [31:0] ta [4];
  logic [31:0] tb_v [4];
  logic [31:0] oa [4];
  logic [31:0] ob [4];

  gf_mult_arbiter #(.DATA_WIDTH(32), .NUM_REQ(4), .MULT_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mult_enable(mult_enable), .mult_a(mult_a),
    .mult_b(mult_b), .mult_result(mult_result), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .op_count(op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) if (b[i]) r = r ^ (64'(a) << i);
    return r;
  endfunction

  // Shared multiplier model: single enable-gated register stage.
  always @(posedge clk) if (mult_enable) mult_result <= clmul(mult_a, mult_b);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    ta   = '{32'h3, 32'h80000001, 32'h12345678, 32'hdeadbeef};
    tb_v = '{32'h3, 32'h80000001, 32'h9abcdef0, 32'hcafef00d};
    oa   = '{32'h5, 32'h00010001, 32'hffff0000, 32'h0f0f0f0f};
    ob   = '{32'h7, 32'h00000003, 32'h0000ffff, 32'h11111111};

    // Reset: outputs zero, ready suppressed even with valid requests
    repeat (2) @(posedge clk);
    #1 req_valid = 4'b1111;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_enable", 64'(mult_enable), 64'h0);
    chk("rst_mult_a", 64'(mult_a), 64'h0);
    chk("rst_mult_b", 64'(mult_b), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_rsp_data", rsp_data, 64'h0);
    chk("rst_op_count", 64'(op_count), 64'h0);
    req_valid = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("enable_on", 64'(mult_enable), 64'h1);

    // Single operation: 0x3 * 0x3 = 0x5, response three cycles on
    req_a[31:0] = 32'h3; req_b[31:0] = 32'h3; req_valid = 4'b0001;
    #1 chk("single_ready", 64'(req_ready), 64'h1);
    @(posedge clk); #1 req_valid = '0;
    chk("single_mult_a", 64'(mult_a), 64'h3);
    @(posedge clk); #1 chk("single_early", 64'(rsp_valid), 64'h0);
    @(posedge clk); #1;
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_rsp_data", rsp_data, 64'h5);
    chk("single_count", 64'(op_count), 64'h1);
    @(posedge clk); #1;
    chk("single_pulse_end", 64'(rsp_valid), 64'h0);
    chk("single_hold", rsp_data, 64'h5);

    // All-ones operands on requester 2
    req_a[95:64] = 32'hffffffff; req_b[95:64] = 32'hffffffff; req_valid = 4'b0100;
    #1 chk("ones_ready", 64'(req_ready), 64'h4);
    @(posedge clk); #1 req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("ones_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("ones_rsp_data", rsp_data, 64'h5555555555555555);
    chk("ones_count", 64'(op_count), 64'h2);

    // Simultaneous requests after reset: grants 0,1,2,3 then responses in order
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = ta[i];
      req_b[i*32 +: 32] = tb_v[i];
    end
    req_valid = 4'b1111;
    #1 chk("sim_grant0", 64'(req_ready), 64'h1);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (k < 4) req_valid[k] = 1'b0;
      #1;
      chk("sim_grant", 64'(req_ready), (k < 3) ? (64'h1 << (k + 1)) : 64'h0);
      if (k >= 2) begin
        chk("sim_rsp_valid", 64'(rsp_valid), 64'h1 << (k - 2));
        chk("sim_rsp_data", rsp_data, clmul(ta[k-2], tb_v[k-2]));
      end else begin
        chk("sim_rsp_idle", 64'(rsp_valid), 64'h0);
      end
    end
    chk("sim_count", 64'(op_count), 64'h4);
    chk("x1_product", clmul(ta[1], tb_v[1]), 64'h4000000000000001);

    // Outstanding limit: requester 1 reissues every third cycle, ready during its response
    @(posedge clk); #1;
    req_a[63:32] = oa[0]; req_b[63:32] = ob[0]; req_valid = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      if (c == 9) req_valid = '0;
      #1;
      chk("lim_ready", 64'(req_ready), (c % 3 == 0 && c < 9) ? 64'h2 : 64'h0);
      if (c >= 3 && c % 3 == 0) begin
        chk("lim_rsp_valid", 64'(rsp_valid), 64'h2);
        chk("lim_rsp_data", rsp_data, clmul(oa[c/3-1], ob[c/3-1]));
      end else begin
        chk("lim_rsp_idle", 64'(rsp_valid), 64'h0);
      end
      @(posedge clk); #1;
      if (c % 3 == 0 && c < 9) begin
        req_a[63:32] = oa[c/3+1];
        req_b[63:32] = ob[c/3+1];
      end
    end

    // Fairness after reset: requesters 0 and 3 alternate
    rst_n = 1'b0;
    #1 chk("rst2_count", 64'(op_count), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1001;
    for (int c = 0; c < 9; c++) begin
      #1;
      chk("fair_grant", 64'(req_ready),
          (c % 3 == 0) ? 64'h1 : (c % 3 == 1) ? 64'h8 : 64'h0);
      chk("fair_rsp", 64'(rsp_valid),
          (c >= 3 && c % 3 == 0) ? 64'h1 : (c >= 4 && c % 3 == 1) ? 64'h8 : 64'h0);
      @(posedge clk); #1;
    end
    req_valid = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset mid-flight: two transfers discarded, ptr back to 0
    req_a[31:0] = 32'h9; req_b[31:0] = 32'h9;
    req_a[63:32] = 32'ha; req_b[63:32] = 32'ha;
    req_valid = 4'b0011;
    #1 chk("mid_grant0", 64'(req_ready), 64'h1);
    @(posedge clk); #1;
    #1 chk("mid_grant1", 64'(req_ready), 64'h2);
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'h0);
    chk("mid_rst_mult_a", 64'(mult_a), 64'h0);
    chk("mid_rst_rsp", 64'(rsp_valid), 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1 chk("mid_no_rsp", 64'(rsp_valid), 64'h0);
      @(posedge clk); #1;
    end
    chk("mid_count", 64'(op_count), 64'h0);
    req_valid = 4'b0101;
    #1 chk("mid_ptr_reset", 64'(req_ready), 64'h1);
    @(posedge clk); #1 req_valid = '0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
